dmem_responder: RTL

- Data-memory responder serving the core's load/store port over a valid/ready request/response handshake; replaces the zero-latency combinational data memory path.
- Models a NUM_WORDS x 32 byte-lane-writable RAM with a programmable access latency, funct3-encoded access sizes, and sign/zero-extended loads.
- Sits between the core's execute stage (initiator) and the writeback mux.

---
 rtl/dmem_responder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: NUM_WORDS x 32 byte-lane RAM behind a valid/ready load/store port with fixed LATENCY.
// Optional build macro DMEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with resp_err_o.
module dmem_responder #(
  parameter int unsigned NUM_WORDS = 32,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_size_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W  = $clog2(NUM_WORDS);
  localparam int unsigned ADDR_W = IDX_W + 2;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [2:0]         size_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               busy_q, busy_d;
  logic [31:0]        mem_q [NUM_WORDS];

  logic               latch_en;
  logic               fire;
  logic               mem_we;
  logic               cur_write;
  logic [ADDR_W-1:0]  cur_addr;
  logic [31:0]        cur_wdata;
  logic [2:0]         cur_size;
  logic [IDX_W-1:0]   cur_idx;
  logic [31:0]        cur_word;
  logic               req_err;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        ld_data;
  logic [3:0]         be;
  logic [31:0]        wd_lanes;
  logic [31:0]        wr_word;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^req_addr_i[31:ADDR_W];

  // With LATENCY==1 the RESP entry edge is the accept edge, so the live request is used directly.
  assign cur_write = (state_q == ST_IDLE) ? req_write_i            : write_q;
  assign cur_addr  = (state_q == ST_IDLE) ? req_addr_i[ADDR_W-1:0] : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? req_wdata_i            : wdata_q;
  assign cur_size  = (state_q == ST_IDLE) ? req_size_i             : size_q;
  assign cur_idx   = cur_addr[ADDR_W-1:2];
  assign cur_word  = mem_q[cur_idx];

  always_comb begin
    req_err = 1'b0;
    case (cur_size)
      SZ_B, SZ_H, SZ_W: req_err = 1'b0;
      SZ_BU, SZ_HU:     req_err = cur_write;
      default:          req_err = 1'b1;
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    if (((cur_size == SZ_H) || (cur_size == SZ_HU)) && cur_addr[0])
      req_err = 1'b1;
    if ((cur_size == SZ_W) && (cur_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  assign byte_sel = cur_word[{cur_addr[1:0], 3'b000} +: 8];
  assign half_sel = cur_addr[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    ld_data = '0;
    case (cur_size)
      SZ_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   ld_data = {24'h0, byte_sel};
      SZ_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   ld_data = {16'h0, half_sel};
      SZ_W:    ld_data = cur_word;
      default: ld_data = '0;
    endcase
  end

  // Store byte enables with data replicated onto every lane.
  always_comb begin
    be       = 4'b0000;
    wd_lanes = cur_wdata;
    case (cur_size)
      SZ_B: begin
        be       = 4'b0001 << cur_addr[1:0];
        wd_lanes = {4{cur_wdata[7:0]}};
      end
      SZ_H: begin
        be       = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{cur_wdata[15:0]}};
      end
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    wr_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) wr_word[8*b +: 8] = wd_lanes[8*b +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    latch_en = 1'b0;
    fire     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          latch_en = 1'b1;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            fire    = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fire) begin
      err_d   = req_err;
      rdata_d = (req_err || cur_write) ? 32'h0 : ld_data;
    end
    mem_we       = fire && cur_write && !req_err;
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      if (latch_en) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i[ADDR_W-1:0];
        wdata_q <= req_wdata_i;
        size_q  <= req_size_i;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[cur_idx] <= wr_word;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign busy_o       = busy_q;

endmodule
